// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// pc_sequencer_pkg : shared state encoding, opcode and condition-code constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_BRANCH = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] CLASS_BRANCH = 2'b11;

    localparam logic [2:0] CC_NEVER  = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_LT     = 3'b010;
    localparam logic [2:0] CC_LE     = 3'b011;
    localparam logic [2:0] CC_ALWAYS = 3'b100;
    localparam logic [2:0] CC_NE     = 3'b101;
    localparam logic [2:0] CC_GE     = 3'b110;
    localparam logic [2:0] CC_GT     = 3'b111;

    localparam logic [7:0] HALT_INSN = 8'hC0;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : instruction-fetch and datapath-issue handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_data;
    logic              exec_valid;
    logic [DATA_W-1:0] exec_instr;
    logic              exec_ready;

    modport master (
        output imem_addr, imem_req, exec_valid, exec_instr,
        input  imem_valid, imem_data, exec_ready
    );

    modport slave (
        input  imem_addr, imem_req, exec_valid, exec_instr,
        output imem_valid, imem_data, exec_ready
    );

endinterface

`default_nettype wire

// File: rtl/pc_cond_eval.sv
// ============================================================================
// pc_cond_eval : branch condition evaluation against a signed operand vs zero
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_cond_eval
    import pc_sequencer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]               code,
    input  logic signed [DATA_W-1:0] value,
    output logic                     taken
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value == '0);
    assign is_neg  = value[DATA_W-1];

    always_comb begin
        taken = 1'b0;
        unique case (code)
            CC_NEVER:  taken = 1'b0;
            CC_EQ:     taken = is_zero;
            CC_LT:     taken = is_neg;
            CC_LE:     taken = is_neg | is_zero;
            CC_ALWAYS: taken = 1'b1;
            CC_NE:     taken = ~is_zero;
            CC_GE:     taken = ~is_neg;
            CC_GT:     taken = ~is_neg & ~is_zero;
            default:   taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : program counter and fetch/issue/branch sequencing controller
// Optional feature macro: PC_SEQ_HALT_INSN_EN (decode 8'hC0 as halt)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    pc_sequencer_if.master           bus,
    input  logic [DATA_W-1:0]        br_target,
    input  logic signed [DATA_W-1:0] br_value,
    output logic [ADDR_W-1:0]        pc,
    output logic                     branch_taken,
    output logic                     halted
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic              imem_req;
    logic              exec_valid;
    logic              cond_taken;

    pc_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
        .code  (ir[2:0]),
        .value (br_value),
        .taken (cond_taken)
    );

    // exec_instr is the instruction register itself, so it cannot move while stalled
    assign bus.imem_addr  = pc;
    assign bus.imem_req   = imem_req;
    assign bus.exec_valid = exec_valid;
    assign bus.exec_instr = ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= '0;
            ir           <= '0;
            imem_req     <= 1'b0;
            exec_valid   <= 1'b0;
            branch_taken <= 1'b0;
            halted       <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bus.imem_valid) begin
                        ir       <= bus.imem_data;
                        imem_req <= 1'b0;
`ifdef PC_SEQ_HALT_INSN_EN
                        if (bus.imem_data == DATA_W'(HALT_INSN)) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else
`endif
                        if (bus.imem_data[7:6] == CLASS_BRANCH) begin
                            state <= ST_BRANCH;
                        end else begin
                            state      <= ST_EXEC;
                            exec_valid <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (bus.exec_ready) begin
                        exec_valid <= 1'b0;
                        pc         <= pc + ADDR_W'(1);
                        if (run) begin
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_BRANCH: begin
                    if (cond_taken) begin
                        pc           <= br_target[ADDR_W-1:0];
                        branch_taken <= 1'b1;
                    end else begin
                        pc <= pc + ADDR_W'(1);
                    end
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : scoreboard bench, directed program with hand-set values
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] br_target = 8'h00;
    logic [7:0] br_value = 8'h00;
    logic [7:0] pc;
    logic       branch_taken;
    logic       halted;

    pc_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    pc_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .bus          (bus.master),
        .br_target    (br_target),
        .br_value     (br_value),
        .pc           (pc),
        .branch_taken (branch_taken),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] instr; logic [7:0] tgt; logic [7:0] val; } prog_t;
    typedef struct packed { logic taken; logic [7:0] pc; } br_exp_t;
    typedef struct packed { logic [7:0] instr; logic [7:0] pc; } ex_exp_t;

    prog_t      prog[$];
    logic [7:0] exp_addr[$];
    ex_exp_t    exp_exec[$];
    br_exp_t    exp_br[$];

    int         checks = 0;
    int         errors = 0;
    int         stall_cnt = 0;
    logic [7:0] model_pc = 8'h00;

    function automatic logic is_branch_insn(input logic [7:0] d);
`ifdef PC_SEQ_HALT_INSN_EN
        if (d == 8'hC0) return 1'b0;
`endif
        return d[7:6] == 2'b11;
    endfunction

    function automatic logic is_halt_insn(input logic [7:0] d);
`ifdef PC_SEQ_HALT_INSN_EN
        return d == 8'hC0;
`else
        return (d == 8'hC0) && 1'b0;
`endif
    endfunction

    function automatic logic cond_model(input logic [2:0] code, input logic [7:0] val);
        int v;
        v = $signed(val);
        case (code)
            3'd0: return 1'b0;
            3'd1: return v == 0;
            3'd2: return v < 0;
            3'd3: return v <= 0;
            3'd4: return 1'b1;
            3'd5: return v != 0;
            3'd6: return v >= 0;
            default: return v > 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_insn(input logic [7:0] instr, input logic [7:0] tgt, input logic [7:0] val);
        logic tk;
        exp_addr.push_back(model_pc);
        if (is_branch_insn(instr)) begin
            tk = cond_model(instr[2:0], val);
            exp_br.push_back({tk, tk ? tgt : model_pc + 8'd1});
            model_pc = tk ? tgt : model_pc + 8'd1;
        end else if (!is_halt_insn(instr)) begin
            exp_exec.push_back({instr, model_pc});
            model_pc = model_pc + 8'd1;
        end
        prog.push_back({instr, tgt, val});
    endtask

    task automatic drain();
        int n = 0;
        while ((prog.size() + exp_addr.size() + exp_exec.size() + exp_br.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 2000), 32'd0);
    endtask

    // Memory / datapath responder: drives inputs just after the active edge
    initial begin
        prog_t p;
        bus.imem_valid = 1'b0;
        bus.imem_data  = 8'h00;
        bus.exec_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.imem_req && prog.size() > 0) begin
                p = prog.pop_front();
                bus.imem_valid = 1'b1;
                bus.imem_data  = p.instr;
                br_target      = p.tgt;
                br_value       = p.val;
            end else begin
                bus.imem_valid = 1'b0;
            end
            if (bus.exec_valid && stall_cnt > 0) begin
                bus.exec_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.exec_ready = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a fetch, issue or branch result
    initial begin
        int         cyc = 0;
        int         fetch_cyc = 0;
        int         br_wait = 0;
        logic       pend = 1'b0;
        logic [7:0] held = 8'h00;
        br_exp_t    be;
        ex_exp_t    ee;
        logic [7:0] ea;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                br_wait = 0;
                pend    = 1'b0;
            end else begin
                if (br_wait == 1) begin
                    if (exp_br.size() == 0) begin
                        chk("branch_unexpected", 32'd1, 32'd0);
                    end else begin
                        be = exp_br.pop_front();
                        chk("branch_taken", 32'(branch_taken), 32'(be.taken));
                        chk("branch_pc", 32'(pc), 32'(be.pc));
                    end
                end else if (branch_taken) begin
                    chk("stray_branch_taken", 32'(branch_taken), 32'd0);
                end
                if (br_wait > 0) br_wait--;

                if (bus.imem_req && bus.imem_valid) begin
                    if (exp_addr.size() == 0) begin
                        chk("fetch_unexpected", 32'd1, 32'd0);
                    end else begin
                        ea = exp_addr.pop_front();
                        chk("imem_addr", 32'(bus.imem_addr), 32'(ea));
                    end
                    fetch_cyc = cyc;
                    if (is_branch_insn(bus.imem_data)) br_wait = 2;
                end

                if (bus.exec_valid) begin
                    if (!pend) begin
                        chk("issue_latency", 32'(cyc - fetch_cyc), 32'd1);
                        held = bus.exec_instr;
                    end else begin
                        chk("exec_instr_stable", 32'(bus.exec_instr), 32'(held));
                    end
                    if (bus.exec_ready) begin
                        pend = 1'b0;
                        if (exp_exec.size() == 0) begin
                            chk("exec_unexpected", 32'd1, 32'd0);
                        end else begin
                            ee = exp_exec.pop_front();
                            chk("exec_instr", 32'(bus.exec_instr), 32'(ee.instr));
                            chk("exec_pc", 32'(pc), 32'(ee.pc));
                        end
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals [5];
        int n;
        vals[0] = 8'h80; vals[1] = 8'hFF; vals[2] = 8'h00; vals[3] = 8'h01; vals[4] = 8'h7F;

        rst_n = 1'b0;
        run   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
        chk("rst_exec_instr", 32'(bus.exec_instr), 32'd0);
        chk("rst_branch_taken", 32'(branch_taken), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic issue, then taken / not-taken branch on negative compare
        run = 1'b1;
        push_insn(8'h05, 8'h00, 8'h00);
        drain();
        push_insn(8'hC2, 8'h40, 8'hFE);
        push_insn(8'hC2, 8'h40, 8'h02);
        drain();

        // All condition codes against signed boundary operands
        for (int c = 0; c < 8; c++) begin
            for (int v = 0; v < 5; v++) begin
                push_insn(8'hC8 | 8'(c), 8'h60 + 8'(c * 5 + v), vals[v]);
            end
        end
        drain();

        // pc wrap 8'hFF -> 8'h00
        push_insn(8'hC4, 8'hFF, 8'h00);
        push_insn(8'h3C, 8'h00, 8'h00);
        push_insn(8'h07, 8'h00, 8'h00);
        drain();

        // Stalled issue with run dropped while waiting
        stall_cnt = 5;
        push_insn(8'h4A, 8'h00, 8'h00);
        n = 0;
        while (!bus.exec_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_exec_valid_seen", 32'(bus.exec_valid), 32'd1);
        repeat (2) @(negedge clk);
        run = 1'b0;
        drain();
        repeat (5) begin
            @(negedge clk);
            chk("idle_imem_req", 32'(bus.imem_req), 32'd0);
        end

        // Halt instruction at pc=3
        rst_n = 1'b0;
        @(negedge clk);
        model_pc = 8'h00;
        chk("rst2_pc", 32'(pc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
        push_insn(8'h01, 8'h00, 8'h00);
        push_insn(8'h02, 8'h00, 8'h00);
        push_insn(8'h03, 8'h00, 8'h00);
        push_insn(8'hC0, 8'h00, 8'h00);
        drain();
        repeat (4) @(negedge clk);
`ifdef PC_SEQ_HALT_INSN_EN
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd3);
        chk("halt_imem_req", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("halt_rst_pc", 32'(pc), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
`else
        chk("nohalt_halted", 32'(halted), 32'd0);
        chk("nohalt_pc", 32'(pc), 32'd4);
`endif
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
